// File: rtl/fetch_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_buffer
//
// Instruction fetch front end. Keeps up to MAX_OUTSTANDING requests in flight
// on the instruction bus, buffers returned words in a DEPTH-entry FIFO, and
// realigns mixed 16/32-bit (RVC) instructions for decode over a valid/ready
// handshake. A redirect flushes the buffer and marks every request still in
// flight as stale, so that its response is dropped when it returns.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   instr_req_o       bus request
//   instr_gnt_i       request accepted this cycle
//   instr_addr_o      word-aligned fetch address
//   instr_rvalid_i    response valid
//   instr_rdata_i     response data
//   instr_err_i       response error (qualified by instr_rvalid_i)
//   redirect_i        PC change (branch/jump/trap)
//   redirect_pc_i     new PC, halfword aligned
//   instr_valid_o     instruction available to decode
//   instr_ready_i     decode accepts the instruction
//   instr_o           instruction; 16-bit ones are zero-extended in [31:16]
//   pc_o              address of instr_o
//   is_compressed_o   instr_o is a 16-bit instruction
//   instr_err_o       a word that instr_o was built from returned an error
//
// Parameters:
//   PC_RESET          fetch address after reset
//   DEPTH             FIFO entries in 32-bit words (>= 2)
//   MAX_OUTSTANDING   granted-but-not-returned request limit (1..DEPTH)
// -----------------------------------------------------------------------------
module fetch_prefetch_buffer #(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int          DEPTH           = 3,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction bus
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  // control flow change
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  // decode side
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o,
  output logic        instr_err_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);   // outstanding / discard
  localparam int CW = $clog2(DEPTH + 1);             // FIFO occupancy
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1; // FIFO pointers

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   fetch_addr_reg;
  logic [31:0]   pc_reg;
  logic [OW-1:0] outstanding_reg;
  logic [OW-1:0] outstanding_next;
  logic [OW-1:0] discard_reg;
  logic [OW-1:0] discard_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_plus1;

  // Each entry is {err, data}. The array is never reset: occupancy is tracked
  // by count_reg, so stale contents are never looked at.
  logic [32:0]   fifo_mem [DEPTH];

  // Circular pointer increment for a depth that need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(DEPTH - 1)) begin
      r = '0;
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus request side
  // ---------------------------------------------------------------------------
  logic [31:0] inflight;
  logic        req_fire;
  logic        rsp_accept;
  logic        rsp_drop;
  logic        push;

  // Requests only go out when there is room for their response: counting
  // in-flight words against the FIFO depth means a push can never overflow.
  assign inflight     = 32'(count_reg) + 32'(outstanding_reg);
  assign instr_req_o  = !rst
                        && (32'(outstanding_reg) < 32'(MAX_OUTSTANDING))
                        && (inflight < 32'(DEPTH));
  assign instr_addr_o = fetch_addr_reg;
  assign req_fire     = instr_req_o && instr_gnt_i;

  // A response with nothing outstanding is ignored so the counter cannot wrap.
  assign rsp_accept   = instr_rvalid_i && (outstanding_reg != '0);
  // Responses to requests issued before a redirect are thrown away.
  assign rsp_drop     = rsp_accept && (discard_reg != '0);
  // A response arriving in the redirect cycle belongs to the old stream too.
  assign push         = rsp_accept && !rsp_drop && !redirect_i;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_fire && !rsp_accept) begin
      outstanding_next = outstanding_reg + OW'(1);
    end else if (!req_fire && rsp_accept) begin
      outstanding_next = outstanding_reg - OW'(1);
    end
  end

  // On a redirect everything still in flight after this cycle's grant and
  // response is stale. Using outstanding_next (rather than adding to the old
  // discard count) keeps back-to-back redirects exact.
  always_comb begin
    discard_next = discard_reg;
    if (redirect_i) begin
      discard_next = outstanding_next;
    end else if (rsp_drop) begin
      discard_next = discard_reg - OW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Aligner on head word W0 and the word behind it, W1
  // ---------------------------------------------------------------------------
  logic [31:0] w0_data;
  logic        w0_err;
  logic [31:0] w1_data;
  logic        w1_err;
  logic        have_w0;
  logic        have_w1;

  logic        aln_valid;
  logic [31:0] aln_instr;
  logic        aln_comp;
  logic        aln_err;
  logic        aln_pop;

  assign rd_ptr_plus1 = ptr_inc(rd_ptr_reg);
  assign w0_data      = fifo_mem[rd_ptr_reg][31:0];
  assign w0_err       = fifo_mem[rd_ptr_reg][32];
  assign w1_data      = fifo_mem[rd_ptr_plus1][31:0];
  assign w1_err       = fifo_mem[rd_ptr_plus1][32];
  assign have_w0      = (count_reg != '0);
  assign have_w1      = (count_reg >= CW'(2));

  always_comb begin
    aln_valid = 1'b0;
    aln_instr = '0;
    aln_comp  = 1'b0;
    aln_err   = 1'b0;
    aln_pop   = 1'b0;
    if (!pc_reg[1]) begin
      aln_valid = have_w0;
      if (w0_err) begin
        // Errored word: present it at once so decode can trap; the pc moves
        // by a full word if it is ever accepted.
        aln_instr = w0_data;
        aln_err   = 1'b1;
        aln_pop   = 1'b1;
      end else if (w0_data[1:0] != 2'b11) begin
        // Low half is a compressed instruction; the upper half is still
        // needed, so the word stays at the head.
        aln_instr = {16'h0, w0_data[15:0]};
        aln_comp  = 1'b1;
      end else begin
        aln_instr = w0_data;
        aln_pop   = 1'b1;
      end
    end else begin
      if (w0_err) begin
        aln_valid = have_w0;
        aln_instr = {16'h0, w0_data[31:16]};
        aln_err   = 1'b1;
        aln_pop   = 1'b1;
      end else if (w0_data[17:16] != 2'b11) begin
        aln_valid = have_w0;
        aln_instr = {16'h0, w0_data[31:16]};
        aln_comp  = 1'b1;
        aln_pop   = 1'b1;
      end else begin
        // 32-bit instruction straddling two words. W0 is retired; W1 stays at
        // the head because its upper half starts the next instruction.
        aln_valid = have_w1;
        aln_instr = {w1_data[15:0], w0_data[31:16]};
        aln_err   = w1_err;
        aln_pop   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode handshake
  // ---------------------------------------------------------------------------
  logic transfer;
  logic pop;

  // Nothing is offered in the redirect cycle: the head belongs to the old
  // stream and the new pc only takes effect next cycle.
  assign instr_valid_o   = !rst && !redirect_i && aln_valid;
  assign instr_o         = instr_valid_o ? aln_instr : 32'h0;
  assign is_compressed_o = instr_valid_o && aln_comp;
  assign instr_err_o     = instr_valid_o && aln_err;
  assign pc_o            = pc_reg;

  assign transfer = instr_valid_o && instr_ready_i;
  assign pop      = transfer && aln_pop;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_reg  <= {PC_RESET[31:2], 2'b00};
      pc_reg          <= PC_RESET;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else if (redirect_i) begin
      // A request granted this cycle went out with the old address and is
      // already included in discard_next.
      fetch_addr_reg  <= {redirect_pc_i[31:2], 2'b00};
      pc_reg          <= redirect_pc_i;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      if (req_fire) begin
        fetch_addr_reg <= fetch_addr_reg + 32'd4;
      end
      if (transfer) begin
        pc_reg <= pc_reg + (aln_comp ? 32'd2 : 32'd4);
      end
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      count_reg       <= count_next;
    end
  end

  // FIFO storage: write-only here, read combinationally at the head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {instr_err_i, instr_rdata_i};
    end
  end

  // A response with no request outstanding means the bus broke its contract.
  always_ff @(posedge clk) begin
    if (!rst && instr_rvalid_i) begin
      assert (outstanding_reg != '0);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        is_compressed_o;
  logic        instr_err_o;

  fetch_prefetch_buffer #(
    .PC_RESET        (32'h100),
    .DEPTH           (3),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_req_o     (instr_req_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_addr_o    (instr_addr_o),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .instr_err_i     (instr_err_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .is_compressed_o (is_compressed_o),
    .instr_err_o     (instr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // memory / bus model state
  int          cyc = 0;
  int          resp_lat = 1;
  int          resp_count = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  logic [31:0] grant_log [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Unlisted addresses hold a 32-bit instruction whose upper half also
  // starts a 32-bit instruction: {addr[15:2], 2'b11, 16'h0013}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (mem.exists(a)) w = mem[a];
    else w = {a[15:2], 2'b11, 16'h0013};
    return w;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    logic [31:0] v;
    if (i < grant_log.size()) v = grant_log[i];
    else v = 32'hDEAD_BEEF;
    return v;
  endfunction

  // grant sampler: well after the negedge, before the next posedge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (instr_req_o && instr_gnt_i) begin
        pend_addr.push_back(instr_addr_o);
        pend_due.push_back(cyc + resp_lat);
        grant_log.push_back(instr_addr_o);
      end
    end
  end

  // response driver: one response per cycle once its latency has elapsed
  initial begin
    logic [31:0] a;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    instr_err_i    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_err_i    = 1'b0;
      end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        a = pend_addr.pop_front();
        void'(pend_due.pop_front());
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(a);
        instr_err_i    = (a == err_addr);
        resp_count++;
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_err_i    = 1'b0;
      end
    end
  end

  // called at a negedge; returns at a negedge with rst just released
  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    grant_log.delete();
    resp_count = 0;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (instr_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_valid_in_time"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    bit found;
    rst           = 1'b1;
    instr_gnt_i   = 1'b1;
    instr_ready_i = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (2) @(negedge clk);

    // ---- reset state ----
    check_eq("rst_req",   instr_req_o, 32'h0);
    check_eq("rst_valid", instr_valid_o, 32'h0);
    check_eq("rst_err",   instr_err_o, 32'h0);
    check_eq("rst_comp",  is_compressed_o, 32'h0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc",    pc_o, 32'h100);

    // ---- 1: zero-wait stream of 32-bit instructions ----
    apply_reset();
    wait_valid("t1", 10);
    check_eq("t1_pc0",    pc_o, 32'h100);
    check_eq("t1_instr0", instr_o, 32'h0103_0013);
    check_eq("t1_comp0",  is_compressed_o, 32'h0);
    @(negedge clk);
    check_eq("t1_pc1",    pc_o, 32'h104);
    check_eq("t1_instr1", instr_o, 32'h0107_0013);
    check_eq("t1_valid1", instr_valid_o, 32'h1);
    @(negedge clk);
    check_eq("t1_pc2",    pc_o, 32'h108);
    check_eq("t1_instr2", instr_o, 32'h010B_0013);
    check_eq("t1_comp2",  is_compressed_o, 32'h0);
    check_eq("t1_addr0",  log_at(0), 32'h100);
    check_eq("t1_addr1",  log_at(1), 32'h104);
    check_eq("t1_addr2",  log_at(2), 32'h108);

    // ---- 2: two compressed instructions in one word ----
    mem[32'h100] = 32'h0001_4501;
    apply_reset();
    wait_valid("t2", 10);
    check_eq("t2_pc0",    pc_o, 32'h100);
    check_eq("t2_instr0", instr_o, 32'h0000_4501);
    check_eq("t2_comp0",  is_compressed_o, 32'h1);
    @(negedge clk);
    check_eq("t2_pc1",    pc_o, 32'h102);
    check_eq("t2_instr1", instr_o, 32'h0000_0001);
    check_eq("t2_comp1",  is_compressed_o, 32'h1);
    @(negedge clk);
    check_eq("t2_pc2",    pc_o, 32'h104);
    check_eq("t2_instr2", instr_o, 32'h0107_0013);
    check_eq("t2_comp2",  is_compressed_o, 32'h0);
    mem.delete(32'h100);

    // ---- 3: redirect to odd halfword with two stale requests in flight ----
    mem[32'h200] = 32'h4567_0001;
    mem[32'h204] = 32'h89AB_CDEF;
    resp_lat = 4;
    apply_reset();
    repeat (2) @(negedge clk);
    check_eq("t3_req_limit", instr_req_o, 32'h0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h202;
    resp_count    = 0;
    @(negedge clk);
    redirect_i = 1'b0;
    grant_log.delete();
    check_eq("t3_pc_new", pc_o, 32'h202);
    wait_valid("t3", 30);
    check_eq("t3_pc",        pc_o, 32'h202);
    check_eq("t3_instr",     instr_o, 32'hCDEF_4567);
    check_eq("t3_comp",      is_compressed_o, 32'h0);
    check_eq("t3_err",       instr_err_o, 32'h0);
    check_eq("t3_resp_seen", resp_count, 32'd4);
    check_eq("t3_addr0",     log_at(0), 32'h200);
    check_eq("t3_addr1",     log_at(1), 32'h204);

    // ---- 4: decode stalled for 10 cycles ----
    resp_lat      = 1;
    instr_ready_i = 1'b0;
    apply_reset();
    wait_valid("t4", 10);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("t4_hold_valid%0d", i), instr_valid_o, 32'h1);
      check_eq($sformatf("t4_hold_pc%0d", i),    pc_o, 32'h100);
      check_eq($sformatf("t4_hold_instr%0d", i), instr_o, 32'h0103_0013);
      @(negedge clk);
    end
    check_eq("t4_req_full", instr_req_o, 32'h0);
    check_eq("t4_ngrants",  grant_log.size(), 32'd3);
    instr_ready_i = 1'b1;
    @(negedge clk);
    check_eq("t4_pc1",    pc_o, 32'h104);
    check_eq("t4_instr1", instr_o, 32'h0107_0013);
    @(negedge clk);
    check_eq("t4_pc2",    pc_o, 32'h108);
    check_eq("t4_instr2", instr_o, 32'h010B_0013);
    @(negedge clk);
    check_eq("t4_pc3",    pc_o, 32'h10C);
    check_eq("t4_instr3", instr_o, 32'h010F_0013);
    check_eq("t4_valid3", instr_valid_o, 32'h1);

    // ---- 5: bus error at 0x108, then redirect back to it ----
    err_addr = 32'h108;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid_o && pc_o == 32'h108) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t5_found",  {31'b0, found}, 32'd1);
    check_eq("t5_valid",  instr_valid_o, 32'h1);
    check_eq("t5_err",    instr_err_o, 32'h1);
    check_eq("t5_comp",   is_compressed_o, 32'h0);
    check_eq("t5_pc",     pc_o, 32'h108);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h108;
    instr_ready_i = 1'b0;
    err_addr      = 32'hFFFF_FFFF;
    #1;
    check_eq("t5_redir_valid", instr_valid_o, 32'h0);
    @(negedge clk);
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    grant_log.delete();
    wait_valid("t5b", 20);
    check_eq("t5b_pc",    pc_o, 32'h108);
    check_eq("t5b_err",   instr_err_o, 32'h0);
    check_eq("t5b_instr", instr_o, 32'h010B_0013);
    check_eq("t5b_addr0", log_at(0), 32'h108);

    // ---- 6: reset while requests are in flight ----
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_req",   instr_req_o, 32'h0);
    check_eq("t6_valid", instr_valid_o, 32'h0);
    check_eq("t6_err",   instr_err_o, 32'h0);
    check_eq("t6_comp",  is_compressed_o, 32'h0);
    check_eq("t6_instr", instr_o, 32'h0);
    check_eq("t6_pc",    pc_o, 32'h100);
    check_eq("t6_addr",  instr_addr_o, 32'h100);
    apply_reset();
    wait_valid("t6b", 10);
    check_eq("t6b_pc",    pc_o, 32'h100);
    check_eq("t6b_instr", instr_o, 32'h0103_0013);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Parametrised next-generation fetch front end. It keeps up to MAX_OUTSTANDING instruction-bus requests in flight and buffers returned words in a DEPTH-entry FIFO.
- It realigns mixed 16/32-bit (RVC) instructions and presents them to decode through a valid/ready handshake.
- Unlike the previous fetch stage, it honours instr_rvalid_i and instr_err_i, and drops stale responses after a redirect.
- It sits between the instruction memory port and the decode stage.

Parameters:
- PC_RESET, 32'h0, fetch address after reset.
- DEPTH, 3, FIFO entries (32-bit words); minimum 2.
- MAX_OUTSTANDING, 2, maximum granted-but-not-returned requests; minimum 1, maximum DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- instr_req_o  out  1  bus request.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_addr_o  out  32  word-aligned fetch address (bits[1:0]=0).
- instr_rvalid_i  in  1  response valid.
- instr_rdata_i  in  32  response data.
- instr_err_i  in  1  response error (qualified by rvalid).
- redirect_i  in  1  PC change (branch/jump/trap).
- redirect_pc_i  in  32  new PC, halfword aligned.
- instr_valid_o  out  1  instruction available.
- instr_ready_i  in  1  decode accepts.
- instr_o  out  32  instruction; compressed instructions are zero-extended in [31:16].
- pc_o  out  32  address of instr_o.
- is_compressed_o  out  1  instr_o is 16-bit.
- instr_err_o  out  1  a word the instruction came from returned an error.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FIFO empty, outstanding=0, discard=0.
  - fetch_addr=PC_RESET&~3, pc=PC_RESET.
  - Outputs: instr_req_o=0, instr_valid_o=0, instr_err_o=0, is_compressed_o=0, instr_o=0, pc_o=PC_RESET.
  - Reset mid-burst abandons in-flight requests. Responses arriving after reset are not counted and are dropped only while discard>0. The bus owner guarantees none arrive.
- Request:
  - instr_req_o=1 when !rst && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding)<DEPTH.
  - instr_addr_o=fetch_addr. On req&&gnt: fetch_addr+=4 and outstanding increments.
  - The address is held stable while req&&!gnt.
- Response: on instr_rvalid_i, outstanding decrements.
  - If discard>0: discard decrements and the data is dropped.
  - Otherwise: {rdata, err} is pushed at the FIFO tail.
  - Push and pop in the same cycle are legal.
  - The FIFO can never overflow; the request rule reserves space.
- Aligner, operating on head word W0 and next word W1:
  - pc[1]=0, W0[1:0]!=2'b11: compressed; needs W0; instr_o={16'h0,W0[15:0]}; consumes half.
  - pc[1]=0, otherwise: 32-bit; needs W0; instr_o=W0; consumes one word.
  - pc[1]=1, W0[17:16]!=2'b11: compressed; needs W0; instr_o={16'h0,W0[31:16]}; pops W0.
  - pc[1]=1, otherwise: 32-bit; needs W0 and W1; instr_o={W1[15:0],W0[31:16]}; pops W0, W1 stays at the head.
  - instr_valid_o=1 when the required words are present.
  - An errored W0 makes the output valid immediately with instr_err_o=1 and is_compressed_o=0. Decode traps on it and does not consume a second word.
  - Unaligned 32-bit: instr_err_o = err(W0)|err(W1).
- Output handshake:
  - Transfer occurs when instr_valid_o&&instr_ready_i; pc advances by 2 (compressed) or 4.
  - Outputs are combinational from FIFO head and pc.
  - Outputs are held stable while valid&&!ready.
  - Latency: first instruction valid at earliest the cycle after rvalid (registered FIFO). Throughput is one 32-bit instruction per cycle with a zero-wait bus.
- Redirect (highest priority after rst):
  - FIFO cleared; pc=redirect_pc_i; fetch_addr=redirect_pc_i&~3.
  - discard = outstanding after this cycle's gnt/rvalid updates.
  - instr_valid_o is forced 0 that cycle.
  - A request may be issued in the same cycle only with the old address. The new address is driven from the next cycle.
  - Redirect with outstanding=0 sets discard=0.
  - Back-to-back redirects accumulate discard correctly.
  - Redirect to an odd halfword (pc[1]=1) skips the low half of the first returned word.
- Counter widths: $clog2(MAX_OUTSTANDING+1) bits for outstanding and discard. Neither may underflow; an rvalid with outstanding=0 is ignored (assertion).

Test Plan:
- Reset, PC_RESET=32'h100, zero-wait memory of 32-bit instructions, ready=1 -> addresses 100,104,108…; pc_o 100,104,108 on consecutive cycles; is_compressed_o=0.
- Word at 0x100 = 32'h0001_4501 (two compressed instructions) -> pc_o 100 then 102, instr_o 32'h0000_4501 then 32'h0000_0001, one bus word consumed.
- Redirect to 32'h202 while 2 requests are outstanding -> both stale responses dropped; next fetch address 0x200; first valid pc_o=0x202; an unaligned 32-bit instruction waits for word 0x204.
- ready=0 for 10 cycles with DEPTH=3 -> at most 3 words buffered; instr_req_o low once full; outputs stable; resumes without loss when ready rises.
- Response with instr_err_i=1 at 0x108 -> instr_valid_o=1, instr_err_o=1, pc_o=0x108; following correct word unaffected after redirect.
- Assert rst during an outstanding request -> all outputs return to reset values next cycle; pc_o=PC_RESET.
